// File: rtl/uart_tx_word_serializer_if.sv
// Handshake bundle between the word serializer, its upstream producer
// and the 8-bit UART transmitter it feeds.
interface uart_tx_word_serializer_if #(
    parameter int WORD_BYTES = 4
);
    logic                    in_valid;
    logic [8*WORD_BYTES-1:0] in_data;
    logic                    in_ready;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    tx_busy;
    logic                    tx_done;

    // Environment side: upstream producer plus transmitter status
    modport master (
        output in_valid, in_data, tx_busy, tx_done,
        input  in_ready, tx_start, tx_data
    );

    // Serializer side
    modport slave (
        input  in_valid, in_data, tx_busy, tx_done,
        output in_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_word_serializer.sv
// Buffers multi-byte result words in a small FIFO and hands them to the
// 8-bit UART transmitter one byte at a time, most significant byte first,
// using the transmitter's busy/done status for flow control.
module uart_tx_word_serializer #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_word_serializer_if.slave bus,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     idle
);
    localparam int W     = 8 * WORD_BYTES;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]       state;
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     shift;
    logic [3:0]       byte_idx;
    logic             push;
    logic             pop;

    assign bus.in_ready = (int'(count) < FIFO_DEPTH);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == S_LOAD);
    assign fifo_count   = count;
    assign idle         = (state == S_IDLE) && (count == '0);

    // Word storage; stale entries are harmless because the pointers are reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    // FIFO pointers and occupancy; a push and pop together leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    // Byte sequencer: one start/busy/done transaction per byte, transmitter
    // status is only looked at while a byte is being handed over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            shift        <= '0;
            byte_idx     <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    shift    <= mem[rd_ptr];
                    byte_idx <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    bus.tx_data <= shift[W-1 -: 8];
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        state        <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (bus.tx_busy) begin
                        bus.tx_start <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        if (byte_idx == 4'(WORD_BYTES - 1)) begin
                            state <= ((count != '0) || push) ? S_LOAD : S_IDLE;
                        end else begin
                            shift    <= shift << 8;
                            byte_idx <= byte_idx + 4'd1;
                            state    <= S_SEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Self-checking bench for uart_tx_word_serializer: a behavioural UART
// transmitter and line decoder surround a 4-byte instance, and a small
// busy/done model drives a 1-byte instance.
module tb_uart_tx_word_serializer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    uart_tx_word_serializer_if #(.WORD_BYTES(4)) bus();
    uart_tx_word_serializer_if #(.WORD_BYTES(1)) bus1();
    logic [3:0] fifo_count;
    logic       idle;
    logic [3:0] fifo_count1;
    logic       idle1;

    uart_tx_word_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .fifo_count(fifo_count), .idle(idle)
    );

    uart_tx_word_serializer #(.WORD_BYTES(1), .FIFO_DEPTH(8), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .fifo_count(fifo_count1), .idle(idle1)
    );

    always #5 clk = ~clk;

    // Cycle counter used for tx_done to tx_start gap measurement
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit,
    // then a one-cycle done pulse; it has no reset, like the real one
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       line = 1'b1;
    logic [7:0] m_byte = 8'h00;
    int         m_bit = 0;
    logic       force_busy = 1'b0;
    assign bus.tx_busy = m_busy | force_busy;
    assign bus.tx_done = m_done;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!m_busy) begin
            if (bus.tx_start) begin
                m_busy <= 1'b1;
                m_byte <= bus.tx_data;
                m_bit  <= 0;
                line   <= 1'b0;
            end
        end else if (m_bit < 8) begin
            line  <= m_byte[m_bit];
            m_bit <= m_bit + 1;
        end else if (m_bit == 8) begin
            line  <= 1'b1;
            m_bit <= 9;
        end else begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
        end
    end

    // Serial line decoder, independent of the transmitter's internals
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];
    always @(negedge clk) begin
        if (rx_cnt == 0) begin
            if (line == 1'b0) rx_cnt = 1;
        end else if (rx_cnt <= 8) begin
            rx_sh  = {line, rx_sh[7:1]};
            rx_cnt = rx_cnt + 1;
        end else begin
            if (line) rx_q.push_back(rx_sh);
            rx_cnt = 0;
        end
    end

    // Records each tx_start run with its data and the gap from the last tx_done
    logic [7:0] start_q[$];
    int         gap_q[$];
    logic       prev_start = 1'b0;
    logic       have_done = 1'b0;
    int         last_done = 0;
    always @(negedge clk) begin
        if (bus.tx_start && !prev_start) begin
            start_q.push_back(bus.tx_data);
            if (have_done) gap_q.push_back(cyc - last_done - 1);
        end
        if (bus.tx_done) begin
            last_done = cyc;
            have_done = 1'b1;
        end
        prev_start = bus.tx_start;
    end

    // Minimal busy/done model for the 1-byte instance
    logic b_busy = 1'b0;
    logic b_done = 1'b0;
    int   b_cnt = 0;
    assign bus1.tx_busy = b_busy;
    assign bus1.tx_done = b_done;
    always @(posedge clk) begin
        b_done <= 1'b0;
        if (!b_busy) begin
            if (bus1.tx_start) begin
                b_busy <= 1'b1;
                b_cnt  <= 3;
            end
        end else if (b_cnt == 0) begin
            b_busy <= 1'b0;
            b_done <= 1'b1;
        end else begin
            b_cnt <= b_cnt - 1;
        end
    end

    // Start-run and gap recorder for the 1-byte instance
    logic [7:0] b_start_q[$];
    int         b_gap_q[$];
    logic       b_prev = 1'b0;
    logic       b_have = 1'b0;
    int         b_last = 0;
    always @(negedge clk) begin
        if (bus1.tx_start && !b_prev) begin
            b_start_q.push_back(bus1.tx_data);
            if (b_have) b_gap_q.push_back(cyc - b_last - 1);
        end
        if (bus1.tx_done) begin
            b_last = cyc;
            b_have = 1'b1;
        end
        b_prev = bus1.tx_start;
    end

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;
    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Push one word; returns at the negedge after the push edge
    task automatic applyStimulus(input logic [31:0] word);
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int k = 0;
        repeat (2) @(negedge clk);
        while (!(idle && !m_busy && rx_cnt == 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, (k < 3000), 1);
    endtask

    task automatic clearLogs();
        start_q.delete();
        gap_q.delete();
        rx_q.delete();
        have_done = 1'b0;
    endtask

    function automatic logic [8:0] qAt(input logic [7:0] q[$], input int idx);
        if (idx < q.size()) return {1'b0, q[idx]};
        return 9'h1FF;
    endfunction

    function automatic logic [7:0] expByte(input vec_t v, input int j);
        case (j)
            0: return v.b0;
            1: return v.b1;
            2: return v.b2;
            default: return v.b3;
        endcase
    endfunction

    initial begin
        int k;
        int n;
        logic ok;

        vecs[0] = '{32'h01234567, 8'h01, 8'h23, 8'h45, 8'h67};
        vecs[1] = '{32'h89ABCDEF, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        vecs[2] = '{32'h00FF00FF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
        vecs[4] = '{32'h7F7F8080, 8'h7F, 8'h7F, 8'h80, 8'h80};
        vecs[5] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
        vecs[6] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[7] = '{32'h0F1E2D3C, 8'h0F, 8'h1E, 8'h2D, 8'h3C};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset tx_start", bus.tx_start, 0);
        checkOutput("reset tx_data", bus.tx_data, 8'h00);
        checkOutput("reset in_ready", bus.in_ready, 1);
        checkOutput("reset fifo_count", fifo_count, 0);
        checkOutput("reset idle", idle, 1);
        checkOutput("reset idle1", idle1, 1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single word 0xDEADBEEF");
        clearLogs();
        applyStimulus(32'hDEADBEEF);
        k = 0;
        while (!bus.tx_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("push-to-start latency", k, 3);
        waitIdle("deadbeef drain");
        checkOutput("deadbeef start runs", start_q.size(), 4);
        checkOutput("deadbeef byte0", qAt(start_q, 0), 9'h0DE);
        checkOutput("deadbeef byte1", qAt(start_q, 1), 9'h0AD);
        checkOutput("deadbeef byte2", qAt(start_q, 2), 9'h0BE);
        checkOutput("deadbeef byte3", qAt(start_q, 3), 9'h0EF);
        checkOutput("deadbeef line count", rx_q.size(), 4);
        checkOutput("deadbeef line0", qAt(rx_q, 0), 9'h0DE);
        checkOutput("deadbeef line3", qAt(rx_q, 3), 9'h0EF);
        checkOutput("intra-word gap", (gap_q.size() == 3) ? gap_q[1] : -1, 1);
        checkOutput("deadbeef idle after", idle, 1);

        $display("[TB] burst of 8 words behind a busy transmitter");
        clearLogs();
        applyStimulus(32'hCAFEF00D);
        k = 0;
        while (!bus.tx_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("burst first start", bus.tx_start, 1);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[i].word;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("full in_ready", bus.in_ready, 0);
        checkOutput("full fifo_count", fifo_count, 8);
        bus.in_data = 32'hBAADBAAD;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("dropped push count", fifo_count, 8);
        waitIdle("burst drain");
        checkOutput("burst start runs", start_q.size(), 36);
        checkOutput("burst line count", rx_q.size(), 36);
        checkOutput("burst head byte", qAt(start_q, 0), 9'h0CA);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                checkOutput($sformatf("burst w%0d b%0d", i, j), qAt(start_q, 4 + 4*i + j), {1'b0, expByte(vecs[i], j)});
                checkOutput($sformatf("burst line w%0d b%0d", i, j), qAt(rx_q, 4 + 4*i + j), {1'b0, expByte(vecs[i], j)});
            end
        end

        $display("[TB] push coincident with last tx_done");
        clearLogs();
        applyStimulus(32'h13579BDF);
        n = 0;
        k = 0;
        while (n < 4 && k < 1000) begin
            @(negedge clk);
            k++;
            if (bus.tx_done) n++;
        end
        checkOutput("last done seen", n, 4);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h2468ACE0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("coincident push count", fifo_count, 1);
        checkOutput("coincident idle", idle, 0);
        waitIdle("coincident drain");
        checkOutput("coincident start runs", start_q.size(), 8);
        checkOutput("coincident word gap", (gap_q.size() == 7) ? gap_q[3] : -1, 2);
        checkOutput("coincident next byte", qAt(start_q, 4), 9'h024);
        checkOutput("coincident last byte", qAt(start_q, 7), 9'h0E0);

        $display("[TB] reset during byte 2");
        clearLogs();
        applyStimulus(32'h11223344);
        k = 0;
        while (start_q.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("second byte started", start_q.size(), 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset tx_start", bus.tx_start, 0);
        checkOutput("midreset tx_data", bus.tx_data, 8'h00);
        checkOutput("midreset in_ready", bus.in_ready, 1);
        checkOutput("midreset fifo_count", fifo_count, 0);
        checkOutput("midreset idle", idle, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(32'hA5A5A5A5);
        waitIdle("post-reset drain");
        checkOutput("post-reset start runs", start_q.size(), 6);
        checkOutput("post-reset first new byte", qAt(start_q, 2), 9'h0A5);
        checkOutput("post-reset last byte", qAt(start_q, 5), 9'h0A5);
        checkOutput("post-reset line count", rx_q.size(), 6);
        checkOutput("in-flight byte on line", qAt(rx_q, 1), 9'h022);
        checkOutput("post-reset line byte", qAt(rx_q, 2), 9'h0A5);

        $display("[TB] transmitter busy held while in SEND");
        clearLogs();
        force_busy = 1'b1;
        applyStimulus(32'h5A0FF05A);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_start) ok = 1'b0;
        end
        checkOutput("start held off", ok, 1);
        checkOutput("held data", bus.tx_data, 8'h5A);
        force_busy = 1'b0;
        @(negedge clk);
        checkOutput("start after busy falls", bus.tx_start, 1);
        waitIdle("held drain");
        checkOutput("held start runs", start_q.size(), 4);
        checkOutput("held byte1", qAt(start_q, 1), 9'h00F);

        $display("[TB] single-byte words");
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h7E;
        @(posedge clk);
        @(negedge clk);
        bus1.in_data = 8'h81;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        k = 0;
        while (!(idle1 && !b_busy && b_start_q.size() >= 2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("w1 drain", (k < 200), 1);
        checkOutput("w1 start runs", b_start_q.size(), 2);
        checkOutput("w1 byte0", qAt(b_start_q, 0), 9'h07E);
        checkOutput("w1 byte1", qAt(b_start_q, 1), 9'h081);
        checkOutput("w1 gap", (b_gap_q.size() == 1) ? b_gap_q[0] : -1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_word_serializer.md
Name: uart_tx_word_serializer

Overview:
- Upstream feeder for the 8-bit UART transmitter.
- Accepts multi-byte result words from the matrix-multiply datapath into a small FIFO.
- Splits each word into bytes, MSB first, and drives the transmitter's start/data inputs one byte at a time.
- Uses the transmitter's busy/done outputs for flow control, so no byte is lost or duplicated on the tx line.

Parameters:
- WORD_BYTES, 4, bytes per input word (1..8).
- FIFO_DEPTH, 8, word FIFO depth; power of two, at least 2.
- CNT_W, 4, width of fifo_count; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  baud-rate clock, shared with the transmitter.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  8*WORD_BYTES  word to transmit.
- in_ready  out  1  FIFO can accept a word.
- tx_start  out  1  to transmitter start.
- tx_data  out  8  to transmitter data input; stable from tx_start assertion until tx_done.
- tx_busy  in  1  from transmitter busy.
- tx_done  in  1  from transmitter done (one-cycle pulse).
- fifo_count  out  CNT_W  words currently stored.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (async, immediate): FSM=IDLE, FIFO pointers and count=0, byte_idx=0, shift reg=0.
- Reset output values: tx_start=0, tx_data=0x00, in_ready=1, fifo_count=0, idle=1.
- Reset mid-transfer: the FIFO is flushed and the partial word is discarded. The transmitter has no reset, so a byte already on the line completes; its tx_done is ignored because only WAIT_DONE samples tx_done.
- FIFO:
  - in_ready = (count < FIFO_DEPTH), combinational from count.
  - Push on in_valid && in_ready.
  - Pop only in LOAD.
  - Push and pop in the same cycle leaves count unchanged.
  - in_valid while full is ignored; the data is not stored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM, all outputs registered:
  - IDLE: if count>0 -> LOAD.
  - LOAD: pop head word into shift reg, byte_idx=0 -> SEND.
  - SEND: tx_data<=shift[top byte]. If tx_busy==0: tx_start<=1 -> ACK. Otherwise stay in SEND; this guards against a stale in-flight byte after reset.
  - ACK: hold tx_start=1 until tx_busy==1, then tx_start<=0 -> WAIT_DONE.
  - WAIT_DONE: on tx_done:
    - if byte_idx==WORD_BYTES-1: -> LOAD if count>0 (count sampled that cycle, including a same-cycle push), else -> IDLE.
    - else: shift reg left by 8, byte_idx+1 -> SEND.
- Byte order: in_data[8*WORD_BYTES-1 -: 8] is sent first, in_data[7:0] last.
- Latency:
  - Push into an empty, idle block: tx_start high 3 cycles after the push edge (IDLE, LOAD, SEND).
  - Gap: tx_done to the next tx_start is 1 cycle within a word, 2 cycles between words.
- tx_start is never high in two separate runs for the same byte. Each byte produces exactly one transmitter transaction.
- tx_busy/tx_done are ignored outside SEND/ACK/WAIT_DONE.
- idle = (state==IDLE) && (count==0).

Test Plan:
- Push 0xDEADBEEF with a behavioural transmitter model -> tx_start asserted 4 times; tx_data DE, AD, BE, EF in order; decoded serial line matches; idle=1 afterward.
- Push 8 words back-to-back while the transmitter is busy -> in_ready=0 and fifo_count=8 after the 8th push. A 9th in_valid is dropped. All 32 bytes emerge in push order.
- Push a word in the same cycle the last byte's tx_done arrives with the FIFO otherwise empty -> word accepted, FSM goes directly to LOAD, no IDLE cycle.
- Assert rst during byte 2 of 0x11223344 -> all outputs at reset values immediately. The in-flight byte finishes on the line. Next pushed word 0xA5A5A5A5 is sent intact starting with A5.
- Force tx_busy=1 for 20 cycles while in SEND -> tx_start stays 0. It asserts the cycle after tx_busy falls.
- WORD_BYTES=1, push 0x7E, 0x81 -> two transactions, 2-cycle gap between tx_done and the next tx_start.
